// File: rtl/recirc_scheduler.sv
// recirc_scheduler -- 4-lane recirculation stage controller.
//   Valid lane bytes are forwarded (registered, latency 1) to the lane mux.
//   Invalid lane bytes are captured into per-lane FIFOs when recirc_en is set.
//   A round-robin arbiter drains the FIFOs onto one valid/ready return channel.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in0..in3, valid_in         lane data and per-lane valid
//   recirc_en                  enable capture of invalid lane bytes
//   data_mux0..3, valid_mux    registered forward data/valid
//   probe_data/lane/valid      return-channel beat to the prober
//   probe_ready                prober accepts the current beat
//   fifo_full                  registered per-lane FIFO full flags
//   drop_count                 (RECIRC_DROP_CNT_EN only) saturating drop counter
// Optional feature macro: RECIRC_DROP_CNT_EN
module recirc_scheduler #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [3:0]        valid_in,
  input  logic              recirc_en,
  output logic [DATA_W-1:0] data_mux0,
  output logic [DATA_W-1:0] data_mux1,
  output logic [DATA_W-1:0] data_mux2,
  output logic [DATA_W-1:0] data_mux3,
  output logic [3:0]        valid_mux,
  output logic [DATA_W-1:0] probe_data,
  output logic [1:0]        probe_lane,
  output logic              probe_valid,
  input  logic              probe_ready,
  output logic [3:0]        fifo_full
`ifdef RECIRC_DROP_CNT_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0] in_lane [4];
  logic [DATA_W-1:0] dmux    [4];
  logic [DATA_W-1:0] mem     [4][DEPTH];
  logic [AW-1:0]     wptr    [4];
  logic [AW-1:0]     rptr    [4];
  logic [AW:0]       count   [4];
  logic [AW:0]       count_nx[4];
  logic [1:0]        rr_ptr;
  logic [3:0]        push, pop, accept, drop;
  logic              found, load;
  logic [1:0]        winner, idx;

  assign in_lane[0] = in0;
  assign in_lane[1] = in1;
  assign in_lane[2] = in2;
  assign in_lane[3] = in3;
  assign data_mux0  = dmux[0];
  assign data_mux1  = dmux[1];
  assign data_mux2  = dmux[2];
  assign data_mux3  = dmux[3];
  assign probe_valid = (state == SEND);

  // Round-robin search over registered counts, so a byte pushed this cycle
  // is only eligible from the next cycle on.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    idx    = rr_ptr;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && count[idx] != '0) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // A new beat is loaded from IDLE, or from SEND when the current beat is taken.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: if (found) begin
        load     = 1'b1;
        state_nx = SEND;
      end
      SEND: if (probe_ready) begin
        load     = found;
        state_nx = found ? SEND : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A full FIFO still accepts a push when it is popped in the same cycle.
  always_comb begin
    pop = load ? (4'b0001 << winner) : 4'b0000;
    for (int unsigned i = 0; i < 4; i++) begin
      push[i]     = !valid_in[i] && recirc_en;
      accept[i]   = push[i] && ((count[i] != FULL_CNT) || pop[i]);
      drop[i]     = push[i] && (count[i] == FULL_CNT) && !pop[i];
      count_nx[i] = count[i] + (AW+1)'(accept[i]) - (AW+1)'(pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++)
      if (accept[i]) mem[i][wptr[i]] <= in_lane[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      probe_data <= '0;
      probe_lane <= '0;
      fifo_full  <= '0;
      valid_mux  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        dmux[i]  <= '0;
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      state     <= state_nx;
      valid_mux <= valid_in;
      if (load) begin
        probe_data <= mem[winner][rptr[winner]];
        probe_lane <= winner;
        rr_ptr     <= winner + 2'd1;
      end
      for (int unsigned i = 0; i < 4; i++) begin
        if (valid_in[i]) dmux[i] <= in_lane[i];
        if (accept[i])   wptr[i] <= wptr[i] + AW'(1);
        if (pop[i])      rptr[i] <= rptr[i] + AW'(1);
        count[i]     <= count_nx[i];
        fifo_full[i] <= (count_nx[i] == FULL_CNT);
      end
    end
  end

`ifdef RECIRC_DROP_CNT_EN
  logic [2:0]  ndrop;
  logic [16:0] drop_sum;

  always_comb begin
    ndrop = 3'd0;
    for (int unsigned i = 0; i < 4; i++) ndrop = ndrop + 3'(drop[i]);
    drop_sum = {1'b0, drop_count} + 17'(ndrop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            drop_count <= '0;
    else if (drop_sum[16]) drop_count <= '1;
    else                  drop_count <= drop_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_recirc_scheduler.sv
// Self-checking bench for recirc_scheduler: directed scenarios plus a
// randomized phase, all checked against a queue-based reference model.
module tb_recirc_scheduler;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din [4];
  logic [3:0] valid_in;
  logic       recirc_en;
  logic       probe_ready;
  logic [7:0] data_mux0, data_mux1, data_mux2, data_mux3;
  logic [3:0] valid_mux;
  logic [7:0] probe_data;
  logic [1:0] probe_lane;
  logic       probe_valid;
  logic [3:0] fifo_full;
`ifdef RECIRC_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  recirc_scheduler #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .valid_in(valid_in), .recirc_en(recirc_en),
    .data_mux0(data_mux0), .data_mux1(data_mux1),
    .data_mux2(data_mux2), .data_mux3(data_mux3),
    .valid_mux(valid_mux),
    .probe_data(probe_data), .probe_lane(probe_lane),
    .probe_valid(probe_valid), .probe_ready(probe_ready),
    .fifo_full(fifo_full)
`ifdef RECIRC_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] q [4][$];
  int         rr;
  logic       m_valid;
  logic [7:0] m_data;
  int         m_lane;
  logic [7:0] exp_dm [4];
  logic [3:0] exp_vm;
  int         m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      exp_dm[i] = 8'h00;
    end
    rr = 0; m_valid = 1'b0; m_data = 8'h00; m_lane = 0;
    exp_vm = 4'h0; m_drop = 0;
  endtask

  // One rising edge: forward path, then arbiter (on pre-push contents),
  // then pushes into whatever space remains after the pop.
  task automatic model_edge();
    bit fnd;
    for (int i = 0; i < 4; i++)
      if (valid_in[i]) exp_dm[i] = din[i];
    exp_vm = valid_in;
    if (!m_valid || probe_ready) begin
      fnd = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int l;
        l = (rr + k) % 4;
        if (!fnd && q[l].size() > 0) begin
          fnd = 1'b1;
          m_data = q[l].pop_front();
          m_lane = l;
          rr = (l + 1) % 4;
        end
      end
      m_valid = fnd;
    end
    for (int i = 0; i < 4; i++)
      if (!valid_in[i] && recirc_en) begin
        if (q[i].size() < DEPTH) q[i].push_back(din[i]);
        else if (m_drop < 65535) m_drop++;
      end
  endtask

  task automatic check_all();
    logic [3:0] ef;
    for (int i = 0; i < 4; i++) ef[i] = (q[i].size() == DEPTH);
    chk("data_mux0", data_mux0, exp_dm[0]);
    chk("data_mux1", data_mux1, exp_dm[1]);
    chk("data_mux2", data_mux2, exp_dm[2]);
    chk("data_mux3", data_mux3, exp_dm[3]);
    chk("valid_mux", valid_mux, exp_vm);
    chk("probe_valid", probe_valid, m_valid);
    if (m_valid) begin
      chk("probe_data", probe_data, m_data);
      chk("probe_lane", probe_lane, m_lane);
    end
    chk("fifo_full", fifo_full, ef);
`ifdef RECIRC_DROP_CNT_EN
    chk("drop_count", drop_count, m_drop);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [3:0] v, input logic en, input logic pr);
    valid_in = v; recirc_en = en; probe_ready = pr;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    drive(4'h0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_probe_valid", probe_valid, 1'b0);
    chk("rst_valid_mux", valid_mux, 4'h0);
    chk("rst_fifo_full", fifo_full, 4'h0);
    chk("rst_data_mux0", data_mux0, 8'h00);
    reset = 1'b0;

    // Forward path
    din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44;
    drive(4'hF, 1'b0, 1'b0);
    step();
    chk("fwd_dm0", data_mux0, 8'h11);
    chk("fwd_dm1", data_mux1, 8'h22);
    chk("fwd_dm2", data_mux2, 8'h33);
    chk("fwd_dm3", data_mux3, 8'h44);
    chk("fwd_vm", valid_mux, 4'hF);
    chk("fwd_pv", probe_valid, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    step();
    chk("fwd_hold_dm2", data_mux2, 8'h33);

    // All four lanes recirculate one byte, drained back-to-back
    for (int i = 0; i < 4; i++) din[i] = 8'hA0 + 8'(i);
    drive(4'h0, 1'b1, 1'b1);
    step();
    drive(4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_pv", probe_valid, 1'b1);
      chk("rr_lane", probe_lane, k);
      chk("rr_data", probe_data, 8'hA0 + 8'(k));
    end
    step();
    chk("rr_idle", probe_valid, 1'b0);

    // Lanes 0 and 3 with three bytes each alternate
    drive(4'b0110, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      din[0] = 8'hB0 + 8'(k); din[3] = 8'hC0 + 8'(k);
      step();
    end
    drive(4'h0, 1'b0, 1'b1);
    chk("alt_lane0", probe_lane, 2'd0);
    chk("alt_data0", probe_data, 8'hB0);
    for (int k = 1; k < 6; k++) begin
      step();
      chk("alt_lane", probe_lane, (k % 2 == 1) ? 3 : 0);
      chk("alt_data", probe_data, (k % 2 == 1) ? 8'hC0 + 8'(k/2) : 8'hB0 + 8'(k/2));
    end
    step();
    chk("alt_idle", probe_valid, 1'b0);

    // Lane 2 overfill while the prober stalls
    drive(4'b1011, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      din[2] = 8'(k);
      step();
    end
    chk("ovf_pd_held", probe_data, 8'h01);
    chk("ovf_full2", fifo_full[2], 1'b1);
`ifdef RECIRC_DROP_CNT_EN
    chk("ovf_drop", drop_count, 16'd1);
`endif
    drive(4'h0, 1'b0, 1'b1);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("ovf_beat", probe_data, 8'(k));
      chk("ovf_lane", probe_lane, 2'd2);
    end
    step();
    chk("ovf_idle", probe_valid, 1'b0);

    // Full lane 1 with simultaneous push/pop every cycle
    drive(4'b1101, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      din[1] = 8'hD0 + 8'(k);
      step();
    end
    chk("fp_full1", fifo_full[1], 1'b1);
    probe_ready = 1'b1;
    for (int k = 5; k < 11; k++) begin
      din[1] = 8'hD0 + 8'(k);
      step();
      chk("fp_full1_hold", fifo_full[1], 1'b1);
      chk("fp_data", probe_data, 8'hD0 + 8'(k - 4));
      chk("fp_lane", probe_lane, 2'd1);
    end
    drive(4'h0, 1'b0, 1'b1);
    repeat (6) step();
    chk("fp_drained", probe_valid, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
      drive(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      step();
    end

    // Reset in the middle of a transfer
    drive(4'h0, 1'b1, 1'b0);
    step();
    step();
    chk("mid_pv_before", probe_valid, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_pv_async", probe_valid, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(4'h0, 1'b0, 1'b1);
    chk("mid_ff_after", fifo_full, 4'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_pv_stays0", probe_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
